// File: rtl/jogo_memoria_param.sv
// Sequence-memory game engine: shows a growing LFSR-generated button sequence
// on one-hot LEDs and checks the player's presses level by level.
module jogo_memoria_param #(
  parameter int          N_BOTOES  = 8,
  parameter int          N_NIVEIS  = 8,
  parameter int          T_EXIBE   = 500,
  parameter int          T_PAUSA   = 250,
  parameter int          T_TIMEOUT = 5000,
  parameter int          VIDAS     = 1,
  parameter logic [15:0] SEMENTE   = 16'hACE1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                jogar,
  input  logic [N_BOTOES-1:0] botoes,
  output logic [N_BOTOES-1:0] leds,
  output logic                pronto,
  output logic                ganhou,
  output logic                perdeu,
  output logic [3:0]          db_estado,
  output logic [4:0]          db_nivel,
  output logic [2:0]          db_vidas,
  output logic [4:0]          db_jogada
);

  localparam int BW   = $clog2(N_BOTOES);
  localparam int IW   = $clog2(N_NIVEIS);
  localparam int TM1  = (T_EXIBE > T_PAUSA) ? T_EXIBE : T_PAUSA;
  localparam int TM2  = (TM1 > T_TIMEOUT) ? TM1 : T_TIMEOUT;
  localparam int TMAX = (TM2 > N_NIVEIS) ? TM2 : N_NIVEIS;
  localparam int TW   = $clog2(TMAX) + 1;

  localparam logic [3:0] INICIAL = 4'd0;
  localparam logic [3:0] PREPARA = 4'd1;
  localparam logic [3:0] EXIBE   = 4'd2;
  localparam logic [3:0] PAUSA   = 4'd3;
  localparam logic [3:0] ESPERA  = 4'd4;
  localparam logic [3:0] COMPARA = 4'd5;
  localparam logic [3:0] PROXIMO = 4'd6;
  localparam logic [3:0] ERRO    = 4'd7;
  localparam logic [3:0] GANHOU  = 4'd8;
  localparam logic [3:0] PERDEU  = 4'd9;

  function automatic logic um_quente(input logic [N_BOTOES-1:0] v);
    return (v != {N_BOTOES{1'b0}}) &&
           ((v & (v - {{(N_BOTOES-1){1'b0}}, 1'b1})) == {N_BOTOES{1'b0}});
  endfunction

  logic [3:0]          estado;
  logic [15:0]         lfsr;
  logic [N_BOTOES-1:0] botoes_q;
  logic [N_BOTOES-1:0] lance;
  logic [TW-1:0]       tmr;
  logic [4:0]          nivel;
  logic [4:0]          jogada;
  logic [2:0]          vidas;
  logic                ganhou_f;
  logic                perdeu_f;
  logic [BW-1:0]       seq [N_NIVEIS];

  logic                press;
  logic                inicia;
  logic [BW-1:0]       seq_atual;
  logic [N_BOTOES-1:0] led_alvo;

  // Press edge, start request and the LED pattern of the current step.
  always_comb begin
    press     = (botoes_q == {N_BOTOES{1'b0}}) && (botoes != {N_BOTOES{1'b0}});
    inicia    = jogar && ((estado == INICIAL) || (estado == GANHOU) || (estado == PERDEU));
    seq_atual = seq[jogada[IW-1:0]];
    led_alvo  = {{(N_BOTOES-1){1'b0}}, 1'b1} << seq_atual;
  end

  // Outputs decoded from registered state.
  always_comb begin
    if (estado == EXIBE) begin
      leds = led_alvo;
    end else begin
      leds = {N_BOTOES{1'b0}};
    end
    pronto    = (estado == ESPERA);
    ganhou    = ganhou_f;
    perdeu    = perdeu_f;
    db_estado = estado;
    db_nivel  = nivel;
    db_vidas  = vidas;
    db_jogada = jogada;
  end

  // Free-running LFSR, taps 16,14,13,11.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lfsr <= SEMENTE;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  // Button history; tracks in every state so held buttons never look like a new press.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      botoes_q <= {N_BOTOES{1'b0}};
    end else begin
      botoes_q <= botoes;
    end
  end

  // Sequence memory, filled one entry per cycle while preparing a game.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_NIVEIS; i++) seq[i] <= {BW{1'b0}};
    end else if (estado == PREPARA) begin
      seq[tmr[IW-1:0]] <= lfsr[BW-1:0];
    end
  end

  // Game FSM with its timer, level, step and lives registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado   <= INICIAL;
      tmr      <= {TW{1'b0}};
      nivel    <= 5'd0;
      jogada   <= 5'd0;
      vidas    <= 3'd0;
      lance    <= {N_BOTOES{1'b0}};
      ganhou_f <= 1'b0;
      perdeu_f <= 1'b0;
    end else if (inicia) begin
      estado   <= PREPARA;
      tmr      <= {TW{1'b0}};
      nivel    <= 5'd0;
      jogada   <= 5'd0;
      vidas    <= 3'(VIDAS);
      ganhou_f <= 1'b0;
      perdeu_f <= 1'b0;
    end else begin
      case (estado)
        INICIAL: estado <= INICIAL;
        PREPARA: begin
          if (tmr == TW'(N_NIVEIS - 1)) begin
            estado <= EXIBE;
            tmr    <= {TW{1'b0}};
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        EXIBE: begin
          if (tmr == TW'(T_EXIBE - 1)) begin
            estado <= PAUSA;
            tmr    <= {TW{1'b0}};
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        PAUSA: begin
          if (tmr == TW'(T_PAUSA - 1)) begin
            tmr <= {TW{1'b0}};
            if (jogada < nivel) begin
              jogada <= jogada + 5'd1;
              estado <= EXIBE;
            end else begin
              jogada <= 5'd0;
              estado <= ESPERA;
            end
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        ESPERA: begin
          if (press) begin
            lance  <= botoes;
            estado <= COMPARA;
            tmr    <= {TW{1'b0}};
          end else if (tmr == TW'(T_TIMEOUT - 1)) begin
            estado <= ERRO;
            tmr    <= {TW{1'b0}};
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        COMPARA: begin
          if (um_quente(lance) && (lance == led_alvo)) begin
            if (jogada < nivel) begin
              jogada <= jogada + 5'd1;
              estado <= ESPERA;
              tmr    <= {TW{1'b0}};
            end else begin
              estado <= PROXIMO;
            end
          end else begin
            estado <= ERRO;
          end
        end
        PROXIMO: begin
          if (nivel == 5'(N_NIVEIS - 1)) begin
            estado   <= GANHOU;
            ganhou_f <= 1'b1;
          end else begin
            nivel  <= nivel + 5'd1;
            jogada <= 5'd0;
            tmr    <= {TW{1'b0}};
            estado <= EXIBE;
          end
        end
        ERRO: begin
          vidas <= vidas - 3'd1;
          if (vidas <= 3'd1) begin
            estado   <= PERDEU;
            perdeu_f <= 1'b1;
          end else begin
            jogada <= 5'd0;
            tmr    <= {TW{1'b0}};
            estado <= EXIBE;
          end
        end
        GANHOU: estado <= GANHOU;
        PERDEU: vidas <= 3'd0;
        default: estado <= INICIAL;
      endcase
    end
  end

endmodule
